// File: rtl/rnd_pkg.sv
// Shared types and defaults for the random range mapper.
// Optional reject statistics are enabled with RND_STATS_EN.
package rnd_pkg;

    typedef enum logic {
        WARM = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEF_WIDTH  = 10;
    localparam int DEF_LIMIT  = 600;
    localparam int DEF_DEPTH  = 4;
    localparam int DEF_WARMUP = 8;
    localparam int CNT_W      = 16;

endpackage

// File: rtl/rnd_fifo.sv
// Small synchronous FIFO; the head reads as zero while empty.
// Pointers wrap naturally because DEPTH is a power of two.
module rnd_fifo
    import rnd_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push;
    logic             do_pop;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == (AW+1)'(DEPTH));
    assign rdata = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/rnd_range_mapper.sv
// Discards warm-up LFSR words, then buffers in-range samples in a FIFO.
// Define RND_STATS_EN to add the saturating rej_cnt output.
module rnd_range_mapper
    import rnd_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int LIMIT  = DEF_LIMIT,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int WARMUP = DEF_WARMUP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] rnd_in,
    input  logic             rnd_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overflow
`ifdef RND_STATS_EN
    ,
    output logic [CNT_W-1:0] rej_cnt
`endif
);

    localparam int             WCW       = (WARMUP > 1) ? $clog2(WARMUP) : 1;
    localparam state_t         RST_STATE = (WARMUP == 0) ? RUN : WARM;
    localparam logic [WIDTH:0] LIM       = (WIDTH+1)'(LIMIT);
    localparam logic [WCW-1:0] WLAST     = WCW'((WARMUP > 0) ? WARMUP - 1 : 0);

    state_t         state_q, state_d;
    logic [WCW-1:0] warm_q, warm_d;
    logic           ovf_q, ovf_d;
    logic           in_range;
    logic           push;
    logic           pop;
    logic           full;
    logic           empty;

    // One extra bit so LIMIT == 2^WIDTH accepts every word
    assign in_range  = ({1'b0, rnd_in} < LIM);
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    assign overflow  = ovf_q;

    always_comb begin
        state_d = state_q;
        warm_d  = warm_q;
        ovf_d   = ovf_q;
        push    = 1'b0;
        case (state_q)
            WARM: begin
                if (rnd_valid) begin
                    if (warm_q == WLAST) begin
                        state_d = RUN;
                        warm_d  = '0;
                    end else begin
                        warm_d = warm_q + WCW'(1);
                    end
                end
            end
            RUN: begin
                if (rnd_valid && in_range) begin
                    if (!full || pop) push  = 1'b1;
                    else              ovf_d = 1'b1;
                end
            end
            default: state_d = RST_STATE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RST_STATE;
            warm_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            warm_q  <= warm_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef RND_STATS_EN
    logic [CNT_W-1:0] rej_q, rej_d;

    always_comb begin
        rej_d = rej_q;
        if (state_q == RUN && rnd_valid && !in_range && rej_q != '1) begin
            rej_d = rej_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) rej_q <= '0;
        else     rej_q <= rej_d;
    end

    assign rej_cnt = rej_q;
`endif

    rnd_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (rnd_in),
        .rdata (out_data),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_rnd_range_mapper.sv
// Scoreboard bench: a queue-based reference model predicts every output word.
// Directed scenarios are followed by a randomized phase.
module tb_rnd_range_mapper;

    localparam int WIDTH  = 10;
    localparam int LIMIT  = 600;
    localparam int DEPTH  = 4;
    localparam int WARMUP = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [WIDTH-1:0] rnd_in = '0;
    logic             rnd_valid = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             overflow;
`ifdef RND_STATS_EN
    logic [15:0]      rej_cnt;
`endif

    rnd_range_mapper #(
        .WIDTH  (WIDTH),
        .LIMIT  (LIMIT),
        .DEPTH  (DEPTH),
        .WARMUP (WARMUP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rnd_in    (rnd_in),
        .rnd_valid (rnd_valid),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overflow  (overflow)
`ifdef RND_STATS_EN
        ,
        .rej_cnt   (rej_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model
    int exp_q[$];
    int occ = 0;
    int warm_seen = 0;
    bit running = 0;
    bit ovf_m = 0;
    int rej_m = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every handshake must deliver the oldest predicted word
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got %0d expected none", out_data);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (int'(out_data) != e) begin
                    errors++;
                    $display("FAIL pop_data: got %0d expected %0d", out_data, e);
                end
            end
        end
    end

    task automatic model_reset();
        exp_q.delete();
        occ       = 0;
        warm_seen = 0;
        running   = (WARMUP == 0);
        ovf_m     = 0;
        rej_m     = 0;
    endtask

    task automatic model_step(input bit v, input int d, input bit r);
        bit p;
        bit w;
        p = (occ > 0) && r;
        w = 0;
        if (v) begin
            if (!running) begin
                warm_seen++;
                if (warm_seen == WARMUP) running = 1;
            end else if (d < LIMIT) begin
                if (occ < DEPTH || p) begin
                    exp_q.push_back(d);
                    w = 1;
                end else begin
                    ovf_m = 1;
                end
            end else begin
                if (rej_m < 65535) rej_m++;
            end
        end
        occ = occ + int'(w) - int'(p);
    endtask

    // Check visible state, then drive the next cycle's inputs
    task automatic cyc(input bit v, input int d, input bit r);
        @(posedge clk);
        #1;
        check("out_valid", int'(out_valid), int'(occ > 0));
        check("overflow", int'(overflow), int'(ovf_m));
        if (occ > 0) check("head", int'(out_data), exp_q[0]);
`ifdef RND_STATS_EN
        check("rej_cnt", int'(rej_cnt), rej_m);
`endif
        rst       = 1'b0;
        rnd_valid = v;
        rnd_in    = WIDTH'(d);
        out_ready = r;
        model_step(v, d, r);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst       = 1'b1;
        rnd_valid = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_overflow", int'(overflow), 0);
        rst = 1'b0;
    endtask

    task automatic warmup(input bit r);
        for (int i = 0; i < WARMUP; i++) cyc(1, 5, r);
    endtask

    task automatic idle(input int n, input bit r);
        for (int i = 0; i < n; i++) cyc(0, 0, r);
    endtask

    initial begin
        do_reset();

        // Warm-up words are discarded; the ninth emerges next cycle
        warmup(1);
        cyc(1, 5, 1);
        cyc(0, 0, 1);
        check("warm_first_valid", int'(out_valid), 1);
        check("warm_first_data", int'(out_data), 5);
        idle(2, 1);

        // LIMIT boundary and the all-ones word
        cyc(1, 599, 1);
        cyc(1, 600, 1);
        cyc(1, 1023, 1);
        idle(3, 1);
        check("empty_after_reject", int'(out_valid), 0);

        // Backpressure, overflow, then ordered drain
        cyc(1, 1, 0);
        cyc(1, 2, 0);
        cyc(1, 3, 0);
        cyc(1, 4, 0);
        cyc(1, 5, 0);
        idle(2, 0);
        check("overflow_set", int'(overflow), 1);
        idle(6, 1);

        // Push and pop in the same cycle while full
        do_reset();
        warmup(0);
        cyc(1, 1, 0);
        cyc(1, 2, 0);
        cyc(1, 3, 0);
        cyc(1, 4, 0);
        cyc(1, 7, 1);
        cyc(0, 0, 0);
        check("full_pushpop_ovf", int'(overflow), 0);
        check("full_pushpop_head", int'(out_data), 2);
        idle(6, 1);

        // Mid-stream reset with three entries buffered
        cyc(1, 10, 0);
        cyc(1, 11, 0);
        cyc(1, 12, 0);
        do_reset();
        warmup(1);
        check("rewarm_empty", int'(out_valid), 0);
        cyc(1, 42, 1);
        cyc(0, 0, 1);
        check("rewarm_first", int'(out_data), 42);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            int d;
            d = ($urandom_range(0, 3) == 0) ? int'($urandom_range(LIMIT, 1023))
                                            : int'($urandom_range(0, LIMIT - 1));
            cyc($urandom_range(0, 3) != 0, d, $urandom_range(0, 2) != 0);
        end
        idle(DEPTH + 4, 1);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rnd_range_mapper.md
RND_RANGE_MAPPER -- requirements
Module: rnd_range_mapper

Interface
REQ-001 SHALL have parameter WIDTH, default 10, meaning bit width of the incoming LFSR word and of out_data.
REQ-002 SHALL have parameter LIMIT, default 600, meaning the exclusive upper bound of emitted values; legal range 1..2^WIDTH.
REQ-003 SHALL have parameter DEPTH, default 4, meaning output FIFO entries; a power of two, at least 2.
REQ-004 SHALL have parameter WARMUP, default 8, meaning the number of valid input words discarded after reset; 0 is legal.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-006 SHALL have port rst, input, 1; one clock, reset synchronous and active-high.
REQ-007 SHALL have port rnd_in, input, WIDTH, the pseudo-random word from the upstream LFSR stage.
REQ-008 SHALL have port rnd_valid, input, 1; rnd_in is sampled only when it is 1.
REQ-009 SHALL have port out_data, output, WIDTH, the FIFO head value, always less than LIMIT.
REQ-010 SHALL have port out_valid, output, 1, high while the FIFO is non-empty.
REQ-011 SHALL have port out_ready, input, 1, the downstream accept signal.
REQ-012 SHALL have port overflow, output, 1, a sticky flag set when an in-range sample is dropped because the FIFO is full.
REQ-013 SHALL have port rej_cnt, output, 16, the out-of-range reject count, present only under RND_STATS_EN.

Function
REQ-014 SHALL implement a two-state FSM: WARM (after reset) and RUN.
REQ-015 In WARM: SHALL count valid inputs; each is discarded, not pushed and not counted as a reject.
REQ-016 In WARM: SHALL go to RUN on the cycle the WARMUP-th valid input is consumed; with WARMUP=0 it SHALL leave reset directly in RUN.
REQ-017 In RUN, valid input with rnd_in < LIMIT: SHALL push into the FIFO when not full, or when full with a pop in the same cycle.
REQ-018 In RUN, valid input with rnd_in >= LIMIT: SHALL reject it; nothing is pushed.
REQ-019 When LIMIT = 2^WIDTH, SHALL never reject.
REQ-020 Latency: a pushed value SHALL be visible on out_data, with out_valid high, no earlier than the next cycle; there SHALL be no combinational path from rnd_in to out_*.
REQ-021 A pop SHALL occur when out_valid && out_ready; FIFO order SHALL be preserved.
REQ-022 out_data and out_valid SHALL hold stable while out_valid && !out_ready.
REQ-023 Full with no pop and an in-range sample: SHALL drop the sample, set overflow, and leave FIFO contents unchanged.
REQ-024 Empty with out_ready high: SHALL perform no pop; out_valid stays 0.
REQ-025 FIFO read/write pointers SHALL wrap modulo DEPTH.
REQ-026 The occupancy count SHALL be log2(DEPTH)+1 bits wide.

Reset
REQ-027 On rst=1 at a clock edge: SHALL set state WARM (or RUN if WARMUP=0), clear the warmup count, empty the FIFO (out_valid=0), set out_data=0, clear overflow, and clear rej_cnt.
REQ-028 Reset asserted mid-operation SHALL discard all buffered samples, with no pop reported that cycle.

Configuration
REQ-029 With macro RND_STATS_EN defined: rej_cnt SHALL increment by 1 per RUN-state reject and saturate at 0xFFFF.
REQ-030 Without RND_STATS_EN: the rej_cnt port and counter SHALL be absent; all other behaviour is unchanged.

Structure
REQ-031 Package rnd_pkg SHALL hold the state enum (WARM, RUN), the default WIDTH/LIMIT/DEPTH constants, and the 16-bit counter width constant.
REQ-032 The FIFO SHALL be a sub-module rnd_fifo (parameters WIDTH, DEPTH; push/pop/full/empty).

Verification
REQ-033 Bench SHALL cover warmup: WARMUP=8; drive 8 valid words of 5 -> out_valid stays 0; the 9th word 5 -> out_data=5 and out_valid=1 one cycle later.
REQ-034 Bench SHALL cover the LIMIT boundary: in RUN drive 599 then 600 -> only 599 is emitted; rej_cnt=1 (RND_STATS_EN).
REQ-035 Bench SHALL cover the reset seed: drive 0x3FF (1023) in RUN -> rejected, FIFO stays empty.
REQ-036 Bench SHALL cover backpressure/full: out_ready=0, push 4 in-range values (1,2,3,4), then 5 -> overflow=1; then release out_ready -> outputs 1,2,3,4 in order.
REQ-037 Bench SHALL cover simultaneous push and pop while full: FIFO full with out_ready=1 and input 7 -> 7 accepted, overflow stays 0.
REQ-038 Bench SHALL cover mid-stream reset: rst for 1 cycle with 3 entries buffered -> out_valid=0, overflow=0, and the warmup restarts.
